pixel_fetch: RTL and testbench

PIXEL_FETCH -- requirements
Module: pixel_fetch

---
 rtl/pixel_fetch.sv | 122 ++++++++++++
 tb/tb_pixel_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch.sv
// Fetches one column of up to 16 pixels from memory, one outstanding read at a time,
// and presents the packed column on pix_col with a one-cycle scratch_rdy pulse.
module pixel_fetch (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic         zero,
  input  logic [11:0]  row,
  input  logic [11:0]  column,
  input  logic [11:0]  width,
  input  logic [19:0]  offset,
  input  logic [3:0]   filter_size,
  output logic         scratch_rdy,
  output logic [127:0] pix_col,
  output logic         mem_rd_en,
  output logic [19:0]  mem_addr,
  input  logic         mem_rd_valid,
  input  logic [7:0]   mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  k_reg, k_next;
  logic [11:0] row_reg, column_reg, width_reg;
  logic [19:0] offset_reg;
  logic [3:0]  filter_size_reg;
  logic [7:0]  lane_reg [16];

  logic        capture;
  logic        lane_wr;
  logic [11:0] row_k;
  logic [23:0] prod;
  logic [19:0] addr_calc;

  assign capture = (state_reg == IDLE) && load_en;
  assign lane_wr = (state_reg == WAIT) && mem_rd_valid;

  // Row index wraps at 12 bits; product truncated to 20 bits; sum wraps at 2^20.
  assign row_k     = row_reg + {8'b0, k_reg};
  assign prod      = {12'b0, row_k} * {12'b0, width_reg};
  assign addr_calc = offset_reg + prod[19:0] + {8'b0, column_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      k_reg           <= 4'd0;
      row_reg         <= 12'd0;
      column_reg      <= 12'd0;
      width_reg       <= 12'd0;
      offset_reg      <= 20'd0;
      filter_size_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      if (capture) begin
        row_reg         <= row;
        column_reg      <= column;
        width_reg       <= width;
        offset_reg      <= offset;
        filter_size_reg <= filter_size;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    scratch_rdy = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = 20'd0;
    case (state_reg)
      IDLE: begin
        if (load_en) begin
          k_next     = 4'd0;
          state_next = zero ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        mem_rd_en  = 1'b1;
        mem_addr   = addr_calc;
        state_next = WAIT;
      end
      WAIT: begin
        if (mem_rd_valid) begin
          if (k_reg == filter_size_reg) begin
            state_next = DONE;
          end else begin
            k_next     = k_reg + 4'd1;
            state_next = ISSUE;
          end
        end
      end
      DONE: begin
        scratch_rdy = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
        k_next     = 4'd0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      // Lanes beyond the requested size are zeroed at capture so they never carry stale pixels.
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg[gi] <= 8'd0;
        end else if (capture && (zero || (4'(gi) > filter_size))) begin
          lane_reg[gi] <= 8'd0;
        end else if (lane_wr && (k_reg == 4'(gi))) begin
          lane_reg[gi] <= mem_rd_data;
        end
      end
      assign pix_col[8*gi +: 8] = lane_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_pixel_fetch.sv
// Scoreboard bench for pixel_fetch: driver pushes expected reads/columns, a monitor
// compares them as the DUT presents them, and a responder models the memory.
module tb_pixel_fetch;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_en = 1'b0;
  logic         zero = 1'b0;
  logic [11:0]  row = '0, column = '0, width = '0;
  logic [19:0]  offset = '0;
  logic [3:0]   filter_size = '0;
  logic         scratch_rdy, mem_rd_en;
  logic [127:0] pix_col;
  logic [19:0]  mem_addr;
  logic         mem_rd_valid = 1'b0;
  logic [7:0]   mem_rd_data = '0;

  pixel_fetch dut (
    .clk(clk), .rst(rst), .load_en(load_en), .zero(zero), .row(row), .column(column),
    .width(width), .offset(offset), .filter_size(filter_size), .scratch_rdy(scratch_rdy),
    .pix_col(pix_col), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int done_cnt = 0, issue_cnt = 0, stray_req = 0, lat_fixed = 0;
  logic [7:0]   mem_key = '0;
  logic [19:0]  exp_addr_q[$];
  logic [127:0] exp_col_q[$];
  logic [127:0] last_col = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Address rule written as plain integer arithmetic.
  function automatic logic [19:0] addr_of(int o, int r, int c, int w, int k);
    int rk, p, s;
    rk = (r + k) % 4096;
    p  = (rk * w) % 1048576;
    s  = (o + p + c) % 1048576;
    return 20'(s);
  endfunction

  // Monitor
  initial forever begin
    @(negedge clk);
    if (mem_rd_en) begin
      if (exp_addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got addr %h expected no read", mem_addr);
      end else begin
        check("mem_addr", {108'b0, mem_addr}, {108'b0, exp_addr_q.pop_front()});
      end
      issue_cnt++;
    end
    if (scratch_rdy) begin
      if (exp_col_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rdy: got scratch_rdy=1 expected 0");
      end else begin
        check("pix_col", pix_col, exp_col_q.pop_front());
      end
      last_col = pix_col;
      done_cnt++;
    end
  end

  // Memory responder: data = addr[7:0] ^ mem_key after 1..3 cycles in WAIT.
  initial begin
    int seen;
    int lat;
    logic [19:0] a;
    seen = 0;
    @(negedge clk);
    forever begin
      if (stray_req != seen) begin
        seen = stray_req;
        mem_rd_valid = 1'b1; mem_rd_data = 8'hEE;
        @(negedge clk);
        mem_rd_valid = 1'b0;
      end else if (mem_rd_en) begin
        a = mem_addr;
        lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
        @(negedge clk);
        repeat (lat - 1) @(negedge clk);
        mem_rd_valid = 1'b1; mem_rd_data = a[7:0] ^ mem_key;
        @(negedge clk);
        mem_rd_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic scramble();
    row = 12'($urandom); column = 12'($urandom); width = 12'($urandom);
    offset = 20'($urandom); filter_size = 4'($urandom);
  endtask

  task automatic fetch(input logic z, input logic [11:0] r, input logic [11:0] c,
                       input logic [11:0] w, input logic [19:0] o, input logic [3:0] fs,
                       output int cyc);
    logic [127:0] col;
    logic [19:0]  a;
    int d0;
    col = '0;
    if (!z) begin
      for (int k = 0; k <= int'(fs); k++) begin
        a = addr_of(o, r, c, w, k);
        exp_addr_q.push_back(a);
        col[8*k +: 8] = a[7:0] ^ mem_key;
      end
    end
    exp_col_q.push_back(col);
    @(negedge clk); #1;
    load_en = 1'b1; zero = z; row = r; column = c; width = w; offset = o; filter_size = fs;
    d0 = done_cnt;
    @(negedge clk); #1;
    load_en = 1'b0; zero = 1'($urandom); scramble();
    cyc = 1;
    while (done_cnt == d0 && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
      scramble();
    end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: got no scratch_rdy after %0d cycles expected one", cyc);
      exp_addr_q.delete(); exp_col_q.delete();
    end
  endtask

  initial begin
    int cyc, d0, i0, t;
    logic [3:0] fs;
    repeat (3) @(negedge clk);
    check("rst_pix_col", pix_col, 128'd0);
    check("rst_scratch_rdy", {127'b0, scratch_rdy}, 128'd0);
    check("rst_mem_rd_en", {127'b0, mem_rd_en}, 128'd0);
    check("rst_mem_addr", {108'b0, mem_addr}, 128'd0);
    #1 rst = 1'b0;

    // Zero column: one-cycle latency, no reads
    fetch(1'b1, 12'd5, 12'd6, 12'd7, 20'h12345, 4'd9, cyc);
    check("zero_latency", 128'(cyc), 128'd1);

    // Basic fetch with literal expected column
    fetch(1'b0, 12'd2, 12'd3, 12'd10, 20'h00100, 4'd2, cyc);
    check("basic_literal", last_col, 128'h2B2117);

    // Full width, single-cycle memory: exact minimum latency
    lat_fixed = 1;
    fetch(1'b0, 12'd0, 12'd0, 12'd1, 20'hFFFF0, 4'd15, cyc);
    check("full_latency", 128'(cyc), 128'd33);
    check("full_literal", last_col, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    lat_fixed = 0;

    // Address wrap at 2^20
    fetch(1'b0, 12'd0, 12'd0, 12'd1, 20'hFFFFE, 4'd3, cyc);
    check("wrap_literal", last_col, 128'h0100FFFE);

    // Stray valid in IDLE is ignored
    d0 = done_cnt;
    @(negedge clk); #1 stray_req++;
    repeat (4) @(negedge clk);
    #1;
    check("stray_pix_col", pix_col, last_col);
    check("stray_no_rdy", 128'(done_cnt - d0), 128'd0);

    // Mid-fetch reset with late valid
    lat_fixed = 3;
    exp_addr_q.push_back(addr_of(20'h00200, 12'd1, 12'd1, 12'd4, 0));
    @(negedge clk); #1;
    load_en = 1'b1; zero = 1'b0; row = 12'd1; column = 12'd1; width = 12'd4;
    offset = 20'h00200; filter_size = 4'd3;
    d0 = done_cnt; i0 = issue_cnt;
    @(negedge clk); #1 load_en = 1'b0;
    t = 0;
    while (issue_cnt == i0 && t < 20) begin @(negedge clk); #1; t++; end
    check("midrst_issued", 128'(issue_cnt - i0), 128'd1);
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("midrst_no_rdy", 128'(done_cnt - d0), 128'd0);
    check("midrst_pix_col", pix_col, 128'd0);
    exp_addr_q.delete();
    lat_fixed = 0;
    fetch(1'b1, 12'd0, 12'd0, 12'd0, 20'd0, 4'd0, cyc);
    check("midrst_idle_latency", 128'(cyc), 128'd1);

    // Randomized fetches
    for (int n = 0; n < 24; n++) begin
      mem_key = 8'($urandom);
      fs = 4'($urandom);
      fetch(($urandom_range(0, 3) == 0), 12'($urandom), 12'($urandom), 12'($urandom),
            20'($urandom), fs, cyc);
    end

    repeat (4) @(negedge clk);
    #1;
    check("queues_drained", 128'(exp_addr_q.size() + exp_col_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
